io_port_controller: RTL and testbench
=====================================

# io_port_controller

Peripheral-side responder for the processor's I/O port and interrupt interface. Buffers externally supplied words into an input FIFO whose head drives the processor's `input_port`, and captures processor `out_port` writes into an output FIFO drained by an external consumer. Raises a rate-limited, one-cycle `interrupt_signal` pulse when input data arrives in an empty FIFO. Sits at the top level beside `processor`, wired to its `input_port`, `out_port` and `interrupt_signal` pins.

## Interface
Parameters:
- `DATA_W`, 16, port data width
- `IN_DEPTH`, 4, input FIFO entries (power of 2, ≥2)
- `OUT_DEPTH`, 4, output FIFO entries (power of 2, ≥2)
- `HOLDOFF`, 8, minimum idle cycles between interrupt pulses (≥1)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `ext_in_valid`  in  1  external word offered
- `ext_in_data`  in  DATA_W  external word
- `ext_in_ready`  out  1  input FIFO not full
- `input_port`  out  DATA_W  input FIFO head, 0 when empty
- `in_read`  in  1  processor consumed `input_port` this cycle (IN retired)
- `out_port`  in  DATA_W  processor output value
- `out_write`  in  1  processor output strobe (outport enable at write-back)
- `ext_out_valid`  out  1  output FIFO not empty
- `ext_out_data`  out  DATA_W  output FIFO head, 0 when empty
- `ext_out_ready`  in  1  external consumer accepts head
- `irq_en`  in  1  interrupt generation enable
- `interrupt_signal`  out  1  one-cycle interrupt request to processor
- `in_count`  out  $clog2(IN_DEPTH)+1  input FIFO occupancy
- `out_count`  out  $clog2(OUT_DEPTH)+1  output FIFO occupancy
- `status_clr`  in  1  clears sticky error flags
- `in_underflow`  out  1  sticky: `in_read` while input FIFO empty
- `out_overflow`  out  1  sticky: `out_write` while output FIFO full

## Operation
- Both FIFOs: register array, wrapping read/write pointers, count register. Full = count==DEPTH; empty = count==0.
- Input push: `ext_in_valid && ext_in_ready`. `ext_in_ready` = !full, computed from registered count only (no path from `in_read`).
- Input pop: `in_read && !empty`. `in_read` while empty: no state change except `in_underflow` set.
- Simultaneous push+pop (non-empty, not full): count unchanged, both pointers advance.
- Output push: `out_write && !full`. `out_write` while full: word dropped, `out_overflow` set, even if a drain occurs the same cycle.
- Output pop: `ext_out_valid && ext_out_ready`.
- Pointers wrap modulo DEPTH; count never exceeds DEPTH nor goes below 0.
- Sticky flags: set has priority over `status_clr` in the same cycle.
- Interrupt: `pending` flag set on any input push when input FIFO empty and `irq_en`=1; cleared when `irq_en`=0 or on entry to PULSE.
- FSM: IDLE --pending--> PULSE; PULSE --always--> HOLDOFF (counter loaded HOLDOFF-1); HOLDOFF --counter==0--> IDLE, else decrement.
- `interrupt_signal` = (state==PULSE), registered. `pending` may set during PULSE/HOLDOFF and is serviced on return to IDLE. Dropping `irq_en` mid-HOLDOFF does not shorten holdoff.

## Timing
- Reset (async, immediate): pointers, counts, flags, `pending` = 0; FSM = IDLE; all outputs 0 except `ext_in_ready`=1.
- `input_port` / `ext_out_data`: combinational mux of registered array at read pointer; new head visible the cycle after the push edge (write-to-read latency 1 cycle).
- Interrupt latency: push into empty FIFO at edge N → `pending`=1 after N → PULSE after N+1 → `interrupt_signal` high exactly one cycle, between edges N+1 and N+2.
- Pulse spacing: at least HOLDOFF+1 cycles from one pulse's rising edge to the next.
- Reset mid-operation: all buffered words discarded; any active pulse deasserts immediately.

## Test plan
- Reset → `ext_in_ready`=1, `input_port`=0, `ext_out_valid`=0, `interrupt_signal`=0, counts 0.
- `irq_en`=1, push 0x1234 into empty input FIFO at edge N → `input_port`=0x1234 after N; `interrupt_signal` high only in cycle N+1..N+2; `in_read` → `input_port`=0, `in_count`=0.
- Push 4 words 0xA0..0xA3 → `ext_in_ready`=0, fifth offer not taken; pop all → values in order, wrap verified with 4 further words; `in_read` when empty → `in_underflow`=1, cleared by `status_clr`.
- `ext_out_ready`=0, `out_write` 0x0001..0x0005 → first 4 stored, 5th dropped, `out_overflow`=1; release ready → drains 0x0001..0x0004 in order.
- HOLDOFF=8: empty→push, pop, push again 2 cycles after the pulse → second pulse exactly 9 cycles after the first; with `irq_en`=0 no pulse.
- Assert `rst` mid-pulse with 3 words buffered → `interrupt_signal`, counts, `input_port` go 0 without a clock edge.

Source files
------------

// File: rtl/io_port_if.sv
// Processor I/O port and interrupt bundle between io_port_controller (slave)
// and the surrounding system (master: processor pins plus external producer/consumer).
interface io_port_if #(
  parameter int DATA_W    = 16,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
);
  logic                         ext_in_valid;
  logic [DATA_W-1:0]            ext_in_data;
  logic                         ext_in_ready;
  logic [DATA_W-1:0]            input_port;
  logic                         in_read;
  logic [DATA_W-1:0]            out_port;
  logic                         out_write;
  logic                         ext_out_valid;
  logic [DATA_W-1:0]            ext_out_data;
  logic                         ext_out_ready;
  logic                         irq_en;
  logic                         interrupt_signal;
  logic [$clog2(IN_DEPTH):0]    in_count;
  logic [$clog2(OUT_DEPTH):0]   out_count;
  logic                         status_clr;
  logic                         in_underflow;
  logic                         out_overflow;

  modport slave (
    input  ext_in_valid, ext_in_data, in_read, out_port, out_write,
           ext_out_ready, irq_en, status_clr,
    output ext_in_ready, input_port, ext_out_valid, ext_out_data,
           interrupt_signal, in_count, out_count, in_underflow, out_overflow
  );

  modport master (
    output ext_in_valid, ext_in_data, in_read, out_port, out_write,
           ext_out_ready, irq_en, status_clr,
    input  ext_in_ready, input_port, ext_out_valid, ext_out_data,
           interrupt_signal, in_count, out_count, in_underflow, out_overflow
  );
endinterface

// File: rtl/io_port_controller.sv
// Peripheral responder: input FIFO feeding input_port, output FIFO capturing
// out_port writes, and a rate-limited one-cycle interrupt on input arrival.
module io_port_controller #(
  parameter int DATA_W    = 16,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4,
  parameter int HOLDOFF   = 8
) (
  input  logic      clk,
  input  logic      rst,
  io_port_if.slave  bus
);
  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int HW  = $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;

  logic [DATA_W-1:0] in_mem [IN_DEPTH];
  logic [IAW-1:0]    in_wr, in_rd;
  logic [IAW:0]      in_cnt;
  logic              in_full, in_empty, in_push, in_pop;

  logic [DATA_W-1:0] out_mem [OUT_DEPTH];
  logic [OAW-1:0]    out_wr, out_rd;
  logic [OAW:0]      out_cnt;
  logic              out_full, out_empty, out_push, out_pop;

  logic              underflow, overflow;
  state_t            state;
  logic              pending, irq, fire;
  logic [HW-1:0]     hold_cnt;

  assign in_full  = (in_cnt == (IAW+1)'(IN_DEPTH));
  assign in_empty = (in_cnt == '0);
  assign in_push  = bus.ext_in_valid && !in_full;
  assign in_pop   = bus.in_read && !in_empty;

  assign out_full  = (out_cnt == (OAW+1)'(OUT_DEPTH));
  assign out_empty = (out_cnt == '0);
  assign out_push  = bus.out_write && !out_full;
  assign out_pop   = bus.ext_out_ready && !out_empty;

  assign bus.ext_in_ready     = !in_full;
  assign bus.input_port       = in_empty ? '0 : in_mem[in_rd];
  assign bus.in_count         = in_cnt;
  assign bus.ext_out_valid    = !out_empty;
  assign bus.ext_out_data     = out_empty ? '0 : out_mem[out_rd];
  assign bus.out_count        = out_cnt;
  assign bus.in_underflow     = underflow;
  assign bus.out_overflow     = overflow;
  assign bus.interrupt_signal = irq;

  always_ff @(posedge clk) begin
    if (in_push)  in_mem[in_wr]   <= bus.ext_in_data;
    if (out_push) out_mem[out_wr] <= bus.out_port;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_wr     <= '0;
      in_rd     <= '0;
      in_cnt    <= '0;
      out_wr    <= '0;
      out_rd    <= '0;
      out_cnt   <= '0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (in_push)  in_wr  <= in_wr + 1'b1;
      if (in_pop)   in_rd  <= in_rd + 1'b1;
      if (in_push && !in_pop)      in_cnt <= in_cnt + 1'b1;
      else if (!in_push && in_pop) in_cnt <= in_cnt - 1'b1;

      if (out_push) out_wr <= out_wr + 1'b1;
      if (out_pop)  out_rd <= out_rd + 1'b1;
      if (out_push && !out_pop)      out_cnt <= out_cnt + 1'b1;
      else if (!out_push && out_pop) out_cnt <= out_cnt - 1'b1;

      underflow <= (bus.in_read && in_empty) || (underflow && !bus.status_clr);
      overflow  <= (bus.out_write && out_full) || (overflow && !bus.status_clr);
    end
  end

  // The last holdoff cycle services a pending request directly, so the IDLE
  // visit costs no cycle and back-to-back pulses sit HOLDOFF+1 cycles apart.
  assign fire = pending && (state == IDLE || (state == HOLD && hold_cnt == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= 1'b0;
      irq      <= 1'b0;
      hold_cnt <= '0;
    end else begin
      if (in_push && in_empty && bus.irq_en) pending <= 1'b1;
      else if (!bus.irq_en || fire)          pending <= 1'b0;

      irq <= fire;

      case (state)
        IDLE:  if (fire) state <= PULSE;
        PULSE: begin
          state    <= HOLD;
          hold_cnt <= HW'(HOLDOFF - 1);
        end
        HOLD: begin
          if (hold_cnt == '0) state <= fire ? PULSE : IDLE;
          else                hold_cnt <= hold_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_io_port_controller.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based reference model with a cycle-distance interrupt rate limiter.
module tb_io_port_controller;
  localparam int DW = 16;
  localparam int ID = 4;
  localparam int OD = 4;
  localparam int HO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  io_port_if #(.DATA_W(DW), .IN_DEPTH(ID), .OUT_DEPTH(OD)) bus ();

  io_port_controller #(.DATA_W(DW), .IN_DEPTH(ID), .OUT_DEPTH(OD), .HOLDOFF(HO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  int inq[$];
  int outq[$];
  int pulse_q[$];
  bit m_pend, m_irq, m_uf, m_of, have_pulse;
  int last_pulse;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    inq.delete();
    outq.delete();
    m_pend = 0; m_irq = 0; m_uf = 0; m_of = 0; have_pulse = 0; last_pulse = 0;
  endtask

  // Reference behaviour for one rising edge, from the current inputs.
  task automatic model_edge();
    bit was_empty, push, pop, opush, opop, ofull, fire;
    was_empty = (inq.size() == 0);
    push  = bus.ext_in_valid && (inq.size() < ID);
    pop   = bus.in_read && !was_empty;
    ofull = (outq.size() == OD);
    opop  = bus.ext_out_ready && (outq.size() > 0);
    opush = bus.out_write && !ofull;
    if (pop)   void'(inq.pop_front());
    if (push)  inq.push_back(int'(bus.ext_in_data));
    if (opop)  void'(outq.pop_front());
    if (opush) outq.push_back(int'(bus.out_port));
    m_uf = (bus.in_read && was_empty) || (m_uf && !bus.status_clr);
    m_of = (bus.out_write && ofull) || (m_of && !bus.status_clr);
    fire = m_pend && (!have_pulse || (cyc - last_pulse >= HO + 1));
    m_irq = fire;
    if (fire) begin
      have_pulse = 1;
      last_pulse = cyc;
    end
    if (push && was_empty && bus.irq_en) m_pend = 1;
    else if (!bus.irq_en || fire)        m_pend = 0;
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    check("input_port",    32'(bus.input_port),    inq.size() > 0 ? 32'(inq[0]) : 32'd0);
    check("ext_in_ready",  32'(bus.ext_in_ready),  32'(inq.size() < ID));
    check("in_count",      32'(bus.in_count),      32'(inq.size()));
    check("ext_out_valid", 32'(bus.ext_out_valid), 32'(outq.size() > 0));
    check("ext_out_data",  32'(bus.ext_out_data),  outq.size() > 0 ? 32'(outq[0]) : 32'd0);
    check("out_count",     32'(bus.out_count),     32'(outq.size()));
    check("interrupt",     32'(bus.interrupt_signal), 32'(m_irq));
    check("in_underflow",  32'(bus.in_underflow),  32'(m_uf));
    check("out_overflow",  32'(bus.out_overflow),  32'(m_of));
    if (bus.interrupt_signal) pulse_q.push_back(cyc);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.ext_in_valid  = 1'b0;
    bus.ext_in_data   = '0;
    bus.in_read       = 1'b0;
    bus.out_port      = '0;
    bus.out_write     = 1'b0;
    bus.ext_out_ready = 1'b0;
    bus.status_clr    = 1'b0;
  endtask

  task automatic push_in(input logic [DW-1:0] d);
    idle_in();
    bus.ext_in_valid = 1'b1;
    bus.ext_in_data  = d;
    step();
  endtask

  task automatic pop_in();
    idle_in();
    bus.in_read = 1'b1;
    step();
  endtask

  task automatic idle_steps(input int n);
    idle_in();
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    bus.irq_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",     32'(bus.ext_in_ready),     32'd1);
    check("rst_input",     32'(bus.input_port),       32'd0);
    check("rst_out_valid", 32'(bus.ext_out_valid),    32'd0);
    check("rst_irq",       32'(bus.interrupt_signal), 32'd0);
    check("rst_in_count",  32'(bus.in_count),         32'd0);
    check("rst_out_count", 32'(bus.out_count),        32'd0);
    rst = 1'b0;

    // Single word into an empty FIFO with interrupts enabled.
    bus.irq_en = 1'b1;
    pulse_q.delete();
    push_in(16'h1234);
    idle_steps(2);
    check("first_pulse_seen", 32'(pulse_q.size()), 32'd1);
    pop_in();
    idle_steps(12);

    // Fill to full, offer a fifth word, drain, then wrap with four more.
    for (int i = 0; i < 5; i++) push_in(16'(16'hA0 + i));
    for (int i = 0; i < 4; i++) pop_in();
    for (int i = 0; i < 4; i++) push_in(16'(16'hB0 + i));
    for (int i = 0; i < 4; i++) pop_in();
    pop_in();
    idle_steps(1);
    idle_in();
    bus.status_clr = 1'b1;
    step();
    idle_steps(12);

    // Output FIFO overflow while the consumer stalls, then drain.
    for (int i = 1; i <= 5; i++) begin
      idle_in();
      bus.out_write = 1'b1;
      bus.out_port  = 16'(i);
      step();
    end
    idle_in();
    bus.ext_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    idle_in();
    bus.status_clr = 1'b1;
    step();
    idle_steps(2);

    // Pulse spacing: second arrival lands two cycles after the first pulse.
    pulse_q.delete();
    push_in(16'h0011);
    pop_in();
    idle_steps(1);
    push_in(16'h0022);
    idle_steps(14);
    check("pulse_count", 32'(pulse_q.size()), 32'd2);
    if (pulse_q.size() >= 2) check("pulse_gap", 32'(pulse_q[1] - pulse_q[0]), 32'(HO + 1));
    pop_in();
    bus.irq_en = 1'b0;
    push_in(16'h0033);
    idle_steps(12);
    check("no_irq_disabled", 32'(pulse_q.size()), 32'd2);
    pop_in();
    bus.irq_en = 1'b1;
    idle_steps(12);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      bus.ext_in_valid  = 1'($urandom_range(0, 1));
      bus.ext_in_data   = 16'($urandom);
      bus.in_read       = ($urandom_range(0, 2) == 0);
      bus.out_write     = 1'($urandom_range(0, 1));
      bus.out_port      = 16'($urandom);
      bus.ext_out_ready = ($urandom_range(0, 2) != 0);
      bus.irq_en        = ($urandom_range(0, 7) != 0);
      bus.status_clr    = ($urandom_range(0, 15) == 0);
      step();
    end

    // Reset in the middle of a pulse with three words buffered.
    bus.irq_en = 1'b1;
    idle_in();
    bus.in_read       = 1'b1;
    bus.ext_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    idle_steps(12);
    push_in(16'h0101);
    pop_in();
    idle_steps(1);
    push_in(16'h0201);
    push_in(16'h0202);
    push_in(16'h0203);
    idle_in();
    for (int i = 0; i < 20 && !m_irq; i++) step();
    check("pre_rst_pulse", 32'(bus.interrupt_signal), 32'd1);
    check("pre_rst_count", 32'(bus.in_count), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_irq",      32'(bus.interrupt_signal), 32'd0);
    check("mid_rst_in_count", 32'(bus.in_count),         32'd0);
    check("mid_rst_input",    32'(bus.input_port),       32'd0);
    check("mid_rst_ready",    32'(bus.ext_in_ready),     32'd1);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_steps(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
